// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int unsigned MIN_DATA_BITS = 5;
   localparam int unsigned MAX_DATA_BITS = 8;

   // Data-bit count selector: the frame carries the encoded value plus five bits.
   typedef enum logic [1:0] {
      DataBits5 = 2'b00,
      DataBits6 = 2'b01,
      DataBits7 = 2'b10,
      DataBits8 = 2'b11
   } data_bits_t;

   typedef enum logic [2:0] {
      DATA,
      PARITY,
      STOP1,
      STOP2,
      COMPLETE
   } rx_frame_state_t;

   function automatic logic [3:0] num_data_bits(input data_bits_t sel);
      return 4'(sel) + 4'(MIN_DATA_BITS);
   endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous load; load takes priority over increment.
module counter #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // Next count: load wins, otherwise increment when enabled.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Assembles detected UART bits (start bit already stripped) into a byte, checks
// parity and stop bits, and holds the result in a single-entry output register.
module uart_rx_frame_assembler #(
   parameter int unsigned MAX_DATA_BITS = uart_pkg::MAX_DATA_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     bit_in,
   input  logic                     bit_in_valid,
   output logic                     bit_in_ready,
   output logic [MAX_DATA_BITS-1:0] byte_out,
   output logic                     byte_out_valid,
   input  logic                     byte_out_ready,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic                     overrun,
   input  logic [1:0]               cfg_data_bits,
   input  logic                     cfg_parity_en,
   input  logic                     cfg_parity_odd,
   input  logic                     cfg_stop2
);

   import uart_pkg::*;

   rx_frame_state_t state_q, state_d;

   data_bits_t cfg_bits_q;
   logic       cfg_par_en_q, cfg_par_odd_q, cfg_stop2_q;

   logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                     par_q, par_d;
   logic                     par_fail_q, par_fail_d;
   logic                     stop_fail_q, stop_fail_d;

   logic [MAX_DATA_BITS-1:0] byte_q, byte_d;
   logic                     valid_q, valid_d;
   logic                     perr_q, perr_d;
   logic                     ferr_q, ferr_d;
   logic                     ovr_q, ovr_d;

   logic       xfer;
   logic       first_xfer;
   logic       commit;
   logic [2:0] bit_cnt;
   logic [2:0] last_idx;
   logic       cnt_load;
   logic [2:0] cnt_load_val;
   logic       cnt_en;

   // The line cannot be back-pressured.
   assign bit_in_ready = 1'b1;
   assign xfer         = bit_in_valid & bit_in_ready;

   // A bit taken in COMPLETE is the first data bit of the following frame.
   assign first_xfer = xfer & (((state_q == DATA) && (bit_cnt == 3'd0)) ||
                               (state_q == COMPLETE));

   // Index of the final data bit; never reached on the first bit since N >= 5.
   assign last_idx = 3'(num_data_bits(cfg_bits_q) - 4'd1);

   counter #(
      .WIDTH (3)
   ) u_bit_cnt (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .en_i       (cnt_en),
      .count_o    (bit_cnt)
   );

   // Frame FSM, shift register, parity/stop tracking and output register next state.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      par_fail_d   = par_fail_q;
      stop_fail_d  = stop_fail_q;
      cnt_load     = 1'b0;
      cnt_load_val = 3'd0;
      cnt_en       = 1'b0;
      commit       = 1'b0;

      unique case (state_q)
         DATA: begin
            if (xfer) begin
               shreg_d[bit_cnt] = bit_in;
               par_d            = par_q ^ bit_in;
               cnt_en           = 1'b1;
               if (bit_cnt == last_idx) begin
                  state_d = cfg_par_en_q ? PARITY : STOP1;
               end
            end
         end
         PARITY: begin
            if (xfer) begin
               par_fail_d = ((par_q ^ bit_in) != cfg_par_odd_q);
               state_d    = STOP1;
            end
         end
         STOP1: begin
            if (xfer) begin
               stop_fail_d = ~bit_in;
               state_d     = cfg_stop2_q ? STOP2 : COMPLETE;
            end
         end
         STOP2: begin
            if (xfer) begin
               stop_fail_d = stop_fail_q | ~bit_in;
               state_d     = COMPLETE;
            end
         end
         COMPLETE: begin
            commit      = 1'b1;
            shreg_d     = '0;
            par_d       = 1'b0;
            par_fail_d  = 1'b0;
            stop_fail_d = 1'b0;
            cnt_load    = 1'b1;
            state_d     = DATA;
            if (xfer) begin
               shreg_d[0]   = bit_in;
               par_d        = bit_in;
               cnt_load_val = 3'd1;
            end
         end
         default: state_d = DATA;
      endcase

      byte_d  = byte_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = 1'b0;
      if (commit) begin
         // A same-cycle accept frees the slot, so the new frame reloads without overrun.
         if (!valid_q || byte_out_ready) begin
            byte_d  = shreg_q;
            valid_d = 1'b1;
            perr_d  = par_fail_q;
            ferr_d  = stop_fail_q;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && byte_out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DATA;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         par_fail_q  <= 1'b0;
         stop_fail_q <= 1'b0;
         byte_q      <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         par_fail_q  <= par_fail_d;
         stop_fail_q <= stop_fail_d;
         byte_q      <= byte_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

   // Frame configuration, captured on the first data bit and held for the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_bits_q    <= DataBits5;
         cfg_par_en_q  <= 1'b0;
         cfg_par_odd_q <= 1'b0;
         cfg_stop2_q   <= 1'b0;
      end else if (first_xfer) begin
         cfg_bits_q    <= data_bits_t'(cfg_data_bits);
         cfg_par_en_q  <= cfg_parity_en;
         cfg_par_odd_q <= cfg_parity_odd;
         cfg_stop2_q   <= cfg_stop2;
      end
   end

   assign byte_out       = byte_q;
   assign byte_out_valid = valid_q;
   assign parity_err     = perr_q;
   assign frame_err      = ferr_q;
   assign overrun        = ovr_q;

endmodule
